// File: rtl/fpro_bridge_mr.sv
// fpro_bridge_mr: MicroBlaze MCS IO-bus to FPro slot-bus bridge with
// NUM_REGIONS decoded chip-selects and a programmable slave read latency.
// Every access completes with an io_ready pulse, mapped or not.
// Optional feature macro: BRG_BUS_ERR_EN (sticky bus_err flag plus the
// address of the first unmapped access).
module fpro_bridge_mr #(
    parameter logic [31:0] BRG_BASE    = 32'hC000_0000,
    parameter int unsigned NUM_REGIONS = 2,
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned RD_LAT      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       io_addr_strobe,
    input  logic                       io_read_strobe,
    input  logic                       io_write_strobe,
    input  logic [3:0]                 io_byte_enable,
    input  logic [31:0]                io_address,
    input  logic [31:0]                io_write_data,
    output logic [31:0]                io_read_data,
    output logic                       io_ready,
    output logic [NUM_REGIONS-1:0]     fp_cs,
    output logic                       fp_wr,
    output logic                       fp_rd,
    output logic [ADDR_W-1:0]          fp_addr,
    output logic [3:0]                 fp_be,
    output logic [31:0]                fp_wr_data,
    input  logic [32*NUM_REGIONS-1:0]  fp_rd_data
`ifdef BRG_BUS_ERR_EN
    ,
    output logic                       bus_err,
    output logic [31:0]                err_addr
`endif
);

    localparam int unsigned SEL_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned TAG_LO = ADDR_W + SEL_W + 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   region;
    logic               hit;
    logic               is_rd;
    logic [CNT_W-1:0]   cnt;

    logic [SEL_W-1:0]       region_c;
    logic                   hit_c;
    logic [NUM_REGIONS-1:0] cs_onehot_c;
    logic [31:0]            sel_data_c;
    logic                   unused_addr_bits;

`ifdef BRG_BUS_ERR_EN
    logic [31:0]        addr_q;
`endif

    // Byte-offset bits are irrelevant to a word-addressed slot bus.
    assign unused_addr_bits = ^io_address[1:0];

    // Decode the live MCS address into region, hit and one-hot select.
    always_comb begin
        region_c    = io_address[ADDR_W+SEL_W+1:ADDR_W+2];
        hit_c       = (io_address[31:TAG_LO] == BRG_BASE[31:TAG_LO])
                      && (32'(region_c) < NUM_REGIONS)
                      && (io_read_strobe || io_write_strobe);
        cs_onehot_c = NUM_REGIONS'(1'b1) << region_c;
    end

    // Read data of the latched region.
    assign sel_data_c = fp_rd_data[32*int'(region) +: 32];

    // Bridge FSM with registered slot-bus and CPU-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            region       <= '0;
            hit          <= 1'b0;
            is_rd        <= 1'b0;
            cnt          <= '0;
            io_read_data <= 32'h0;
            io_ready     <= 1'b0;
            fp_cs        <= '0;
            fp_wr        <= 1'b0;
            fp_rd        <= 1'b0;
            fp_addr      <= '0;
            fp_be        <= 4'h0;
            fp_wr_data   <= 32'h0;
`ifdef BRG_BUS_ERR_EN
            addr_q       <= 32'h0;
            bus_err      <= 1'b0;
            err_addr     <= 32'h0;
`endif
        end else begin
            fp_wr    <= 1'b0;
            fp_rd    <= 1'b0;
            io_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io_addr_strobe) begin
                        region     <= region_c;
                        hit        <= hit_c;
                        is_rd      <= io_read_strobe;
                        fp_addr    <= io_address[ADDR_W+1:2];
                        fp_be      <= io_byte_enable;
                        fp_wr_data <= io_write_data;
`ifdef BRG_BUS_ERR_EN
                        addr_q     <= io_address;
`endif
                        if (hit_c) begin
                            fp_cs <= cs_onehot_c;
                            fp_rd <= io_read_strobe;
                            fp_wr <= ~io_read_strobe;
                        end
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (hit && is_rd && (RD_LAT > 0)) begin
                        cnt   <= CNT_W'(RD_LAT - 1);
                        state <= S_WAIT;
                    end else begin
                        if (is_rd) begin
                            io_read_data <= hit ? sel_data_c : 32'h0;
                        end
`ifdef BRG_BUS_ERR_EN
                        if (!hit) begin
                            bus_err <= 1'b1;
                            if (!bus_err) begin
                                err_addr <= addr_q;
                            end
                        end else if (bus_err && !is_rd && (region == '0)
                                     && (fp_addr == '0)) begin
                            bus_err <= 1'b0;
                        end
`endif
                        io_ready <= 1'b1;
                        fp_cs    <= '0;
                        state    <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        io_read_data <= sel_data_c;
                        io_ready     <= 1'b1;
                        fp_cs        <= '0;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpro_bridge_mr.sv
// Directed bench for fpro_bridge_mr (NUM_REGIONS=2, ADDR_W=22, RD_LAT=2).
// Region bit is io_address[24], so 0xC100_0008 selects region 1.
module tb_fpro_bridge_mr;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 22;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              io_addr_strobe = 1'b0;
    logic              io_read_strobe = 1'b0;
    logic              io_write_strobe = 1'b0;
    logic [3:0]        io_byte_enable = 4'h0;
    logic [31:0]       io_address = 32'h0;
    logic [31:0]       io_write_data = 32'h0;
    logic [31:0]       io_read_data;
    logic              io_ready;
    logic [NR-1:0]     fp_cs;
    logic              fp_wr;
    logic              fp_rd;
    logic [AW-1:0]     fp_addr;
    logic [3:0]        fp_be;
    logic [31:0]       fp_wr_data;
    logic [32*NR-1:0]  fp_rd_data = {32'h1234_5678, 32'hCAFE_F00D};
`ifdef BRG_BUS_ERR_EN
    logic              bus_err;
    logic [31:0]       err_addr;
`endif

    int errors = 0;
    int checks = 0;

    fpro_bridge_mr #(
        .BRG_BASE    (32'hC000_0000),
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .RD_LAT      (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .fp_cs           (fp_cs),
        .fp_wr           (fp_wr),
        .fp_rd           (fp_rd),
        .fp_addr         (fp_addr),
        .fp_be           (fp_be),
        .fp_wr_data      (fp_wr_data),
        .fp_rd_data      (fp_rd_data)
`ifdef BRG_BUS_ERR_EN
        ,
        .bus_err         (bus_err),
        .err_addr        (err_addr)
`endif
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access: strobe at T0, check T1, wait for io_ready, check latency and pulses.
    task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rd, input logic wr, input logic hit,
                       input logic [NR-1:0] cs, input logic [AW-1:0] fa, input int lat,
                       input logic chk_rd, input logic [31:0] rdat,
                       input logic busy, input int tail);
        int n;
        int nrd;
        int nwr;
        int extra;
        int unstable;
        @(negedge clk);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = addr;
        io_write_data   = wdata;
        io_byte_enable  = 4'hF;
        @(negedge clk);
        check({tag, ".cs"}, 32'(fp_cs), 32'(cs));
        check({tag, ".rd"}, 32'(fp_rd), 32'(rd && hit));
        check({tag, ".wr"}, 32'(fp_wr), 32'(wr && hit && !rd));
        if (hit) begin
            check({tag, ".addr"}, 32'(fp_addr), 32'(fa));
            check({tag, ".be"}, 32'(fp_be), 32'hF);
            if (wr && !rd) check({tag, ".wdata"}, fp_wr_data, wdata);
        end
        nrd = int'(fp_rd);
        nwr = int'(fp_wr);
        unstable = 0;
        io_addr_strobe = busy;
        n = 1;
        while (!io_ready && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) io_addr_strobe = 1'b0;
            nrd += int'(fp_rd);
            nwr += int'(fp_wr);
            if (!io_ready && fp_cs !== cs) unstable++;
        end
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        check({tag, ".ready_cycle"}, 32'(n), 32'(lat));
        check({tag, ".cs_stable"}, 32'(unstable), 32'h0);
        check({tag, ".cs_done"}, 32'(fp_cs), 32'h0);
        check({tag, ".n_rd"}, 32'(nrd), 32'(rd && hit));
        check({tag, ".n_wr"}, 32'(nwr), 32'(wr && hit && !rd));
        if (chk_rd) check({tag, ".rdata"}, io_read_data, rdat);
        if (tail > 0) begin
            extra = 0;
            for (int k = 0; k < tail; k++) begin
                @(negedge clk);
                extra += int'(io_ready) + int'(fp_rd);
            end
            check({tag, ".no_extra"}, 32'(extra), 32'h0);
        end
    endtask

    initial begin
        int late;
        #1;
        check("rst.ready", 32'(io_ready), 32'h0);
        check("rst.cs", 32'(fp_cs), 32'h0);
        check("rst.rdata", io_read_data, 32'h0);
        check("rst.strobes", 32'({fp_rd, fp_wr}), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Write hit then read issued the cycle after io_ready.
        txn("wr_hit", 32'hC000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 2'b01, 22'd4, 2,
            1'b1, 32'h0, 1'b0, 0);
        txn("rd_r1", 32'hC100_0008, 32'h0, 1'b1, 1'b0, 1'b1, 2'b10, 22'd2, 4,
            1'b1, 32'h1234_5678, 1'b0, 3);
        txn("rd_r0", 32'hC000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01, 22'h40, 4,
            1'b1, 32'hCAFE_F00D, 1'b0, 2);
        // Write leaves io_read_data untouched.
        txn("wr_hold", 32'hC000_0020, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1, 2'b01, 22'd8, 2,
            1'b1, 32'hCAFE_F00D, 1'b0, 2);
        txn("rd_miss", 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 22'd0, 2,
            1'b1, 32'h0, 1'b0, 2);
`ifdef BRG_BUS_ERR_EN
        check("err.flag", 32'(bus_err), 32'h1);
        check("err.addr", err_addr, 32'h8000_0000);
        txn("err_clr", 32'hC000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 2'b01, 22'd0, 2,
            1'b0, 32'h0, 1'b0, 1);
        check("err.cleared", 32'(bus_err), 32'h0);
`endif
        // Neither direction qualifier: completes as a miss.
        txn("no_dir", 32'hC000_0004, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 22'd0, 2,
            1'b0, 32'h0, 1'b0, 2);
        // Second strobe during ACCESS is ignored.
        txn("busy", 32'hC100_0008, 32'h0, 1'b1, 1'b0, 1'b1, 2'b10, 22'd2, 4,
            1'b1, 32'h1234_5678, 1'b1, 5);

        // Reset during WAIT drops the access.
        @(negedge clk);
        io_addr_strobe = 1'b1;
        io_read_strobe = 1'b1;
        io_address     = 32'hC100_0008;
        @(negedge clk);
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        check("rstw.t1_rd", 32'(fp_rd), 32'h1);
        @(negedge clk);
        check("rstw.wait_cs", 32'(fp_cs), 32'(2'b10));
        #2 reset = 1'b1;
        #1;
        check("rstw.cs", 32'(fp_cs), 32'h0);
        check("rstw.addr", 32'(fp_addr), 32'h0);
        check("rstw.rdata", io_read_data, 32'h0);
        check("rstw.ready", 32'(io_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        late = 0;
        repeat (6) begin
            @(negedge clk);
            late += int'(io_ready);
        end
        check("rstw.no_ready", 32'(late), 32'h0);
        txn("post_rst", 32'hC000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01, 22'h40, 4,
            1'b1, 32'hCAFE_F00D, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
